// File: rtl/led_counter_ctrl.sv
// LED counter controller: debounced front-panel buttons, remote value load,
// speed-selectable tick prescaler and the 8-bit LED count register.
module led_counter_ctrl #(
    parameter int CLK_FREQ        = 25_000_000,
    parameter int DEBOUNCE_CYCLES = 250_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_run,
    input  logic       btn_step,
    input  logic       btn_clear,
    input  logic       btn_dir,
    input  logic [1:0] speed,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    output logic       load_ready,
    output logic [7:0] leds,
    output logic       running,
    output logic       down,
    output logic       tick
);

    localparam int NUM_BTN   = 4;
    localparam int BTN_RUN   = 0;
    localparam int BTN_STEP  = 1;
    localparam int BTN_CLEAR = 2;
    localparam int BTN_DIR   = 3;

    // The counter never exceeds DEBOUNCE_CYCLES-1, so clog2 bits suffice.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic ST_PAUSE = 1'b0;
    localparam logic ST_RUN   = 1'b1;

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_event;

    assign btn_raw = {btn_dir, btn_clear, btn_step, btn_run};

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            logic             sync1_reg;
            logic             sync2_reg;
            logic             stable_reg;
            logic             stable_prev_reg;
            logic [CNT_W-1:0] db_cnt_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_reg       <= 1'b0;
                    sync2_reg       <= 1'b0;
                    stable_reg      <= 1'b0;
                    stable_prev_reg <= 1'b0;
                    db_cnt_reg      <= '0;
                end else begin
                    sync1_reg       <= btn_raw[gi];
                    sync2_reg       <= sync1_reg;
                    stable_prev_reg <= stable_reg;
                    if (sync2_reg == stable_reg) begin
                        db_cnt_reg <= '0;
                    end else if (db_cnt_reg == CNT_LAST) begin
                        stable_reg <= sync2_reg;
                        db_cnt_reg <= '0;
                    end else begin
                        db_cnt_reg <= db_cnt_reg + 1'b1;
                    end
                end
            end

            // Only the press edge of the debounced level is an event.
            assign btn_event[gi] = stable_reg & ~stable_prev_reg;
        end
    endgenerate

    logic ev_run;
    logic ev_step;
    logic ev_clear;
    logic ev_dir;

    assign ev_run   = btn_event[BTN_RUN];
    assign ev_step  = btn_event[BTN_STEP];
    assign ev_clear = btn_event[BTN_CLEAR];
    assign ev_dir   = btn_event[BTN_DIR];

    logic        state_reg, state_next;
    logic        down_reg, down_next;
    logic [7:0]  leds_reg, leds_next;
    logic        tick_reg, tick_next;
    logic [31:0] prescaler_reg, prescaler_next;
    logic [1:0]  speed_prev_reg;

    logic [31:0] period;
    logic        speed_changed;
    logic        load_fire;
    logic        tick_due;
    logic [7:0]  leds_stepped;

    assign period        = 32'(CLK_FREQ) >> speed;
    assign speed_changed = (speed != speed_prev_reg);
    assign load_ready    = ~rst & ~ev_clear;
    assign load_fire     = load_valid & load_ready;
    assign tick_due      = (state_reg == ST_RUN) && (prescaler_reg == period - 32'd1);
    // Direction is the pre-event value; a same-cycle ev_dir applies afterwards.
    assign leds_stepped  = down_reg ? (leds_reg - 8'd1) : (leds_reg + 8'd1);

    always_comb begin
        state_next = state_reg;
        if (ev_run) begin
            state_next = (state_reg == ST_RUN) ? ST_PAUSE : ST_RUN;
        end
        down_next = down_reg ^ ev_dir;
    end

    always_comb begin
        leds_next = leds_reg;
        tick_next = 1'b0;
        if (ev_clear) begin
            leds_next = 8'h00;
        end else if (load_fire) begin
            leds_next = load_data;
        end else if (ev_step && (state_reg == ST_PAUSE)) begin
            leds_next = leds_stepped;
        end else if (tick_due) begin
            leds_next = leds_stepped;
            tick_next = 1'b1;
        end
    end

    always_comb begin
        prescaler_next = prescaler_reg + 32'd1;
        if ((state_reg == ST_PAUSE) || ev_clear || load_fire || speed_changed || tick_due) begin
            prescaler_next = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_PAUSE;
            down_reg       <= 1'b0;
            leds_reg       <= 8'h00;
            tick_reg       <= 1'b0;
            prescaler_reg  <= 32'd0;
            speed_prev_reg <= 2'd0;
        end else begin
            state_reg      <= state_next;
            down_reg       <= down_next;
            leds_reg       <= leds_next;
            tick_reg       <= tick_next;
            prescaler_reg  <= prescaler_next;
            speed_prev_reg <= speed;
        end
    end

    assign leds    = leds_reg;
    assign running = (state_reg == ST_RUN);
    assign down    = down_reg;
    assign tick    = tick_reg;

endmodule

// File: tb/tb_led_counter_ctrl.sv
// Bench for led_counter_ctrl: directed button/load sequences, a load vector
// table and a randomized RUN-mode run against an elapsed-time model.
module tb_led_counter_ctrl;

    localparam int CLK_FREQ = 16;
    localparam int DEB      = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_run, btn_step, btn_clear, btn_dir;
    logic [1:0] speed;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_ready;
    logic [7:0] leds;
    logic       running, down, tick;

    int checks = 0;
    int errors = 0;
    int tick_seen = 0;

    led_counter_ctrl #(.CLK_FREQ(CLK_FREQ), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .rst(rst),
        .btn_run(btn_run), .btn_step(btn_step), .btn_clear(btn_clear), .btn_dir(btn_dir),
        .speed(speed), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .leds(leds), .running(running), .down(down), .tick(tick)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       lv;
        logic [7:0] ld;
        logic [7:0] exp_leds;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        #1;
        if (tick === 1'b1) tick_seen++;
    endtask

    task automatic set_btn(input int idx, input logic v);
        case (idx)
            0: btn_run = v;
            1: btn_step = v;
            2: btn_clear = v;
            default: btn_dir = v;
        endcase
    endtask

    // Press, hold until the event has taken effect, then release cleanly.
    task automatic press(input int idx);
        set_btn(idx, 1'b1);
        repeat (DEB + 3) tick_clk();
        set_btn(idx, 1'b0);
        repeat (DEB + 3) tick_clk();
    endtask

    // Load val, then expect exactly one tick PERIOD (16) cycles later.
    task automatic load_then_tick(input logic [7:0] val, input logic [7:0] exp);
        int t0;
        load_valid = 1'b1;
        load_data  = val;
        tick_clk();
        load_valid = 1'b0;
        check("load_value", leds, val);
        check("load_no_tick", tick, 0);
        t0 = tick_seen;
        repeat (CLK_FREQ - 1) tick_clk();
        check("quiet_period", tick_seen - t0, 0);
        tick_clk();
        check("tick_after_period", tick, 1);
        check("tick_value", leds, exp);
        $display("load %02h then tick -> leds %02h", val, leds);
    endtask

    initial begin
        int t0;
        int toggles;
        logic last_run;
        logic [24:0] bounce;
        int m_e;
        int per;
        logic [7:0] m_leds;
        logic m_tick;
        logic [1:0] m_sprev, spd, nspd;
        logic lv;
        logic [7:0] ld;

        vecs[0] = '{1'b1, 8'h3C, 8'h3C};
        vecs[1] = '{1'b0, 8'h99, 8'h3C};
        vecs[2] = '{1'b1, 8'h00, 8'h00};
        vecs[3] = '{1'b1, 8'hFF, 8'hFF};
        vecs[4] = '{1'b1, 8'h80, 8'h80};
        vecs[5] = '{1'b0, 8'h11, 8'h80};
        vecs[6] = '{1'b1, 8'h7F, 8'h7F};
        vecs[7] = '{1'b1, 8'h01, 8'h01};

        rst = 1'b1;
        btn_run = 0; btn_step = 0; btn_clear = 0; btn_dir = 0;
        speed = 2'd0; load_valid = 0; load_data = 8'h00;

        // Test 1: reset state, run press, free counting at speed 0.
        repeat (3) tick_clk();
        check("rst_leds", leds, 0);
        check("rst_running", running, 0);
        check("rst_down", down, 0);
        check("rst_tick", tick, 0);
        check("rst_load_ready", load_ready, 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", load_ready, 1);
        btn_run = 1'b1;
        for (int k = 1; k <= DEB + 3; k++) begin
            tick_clk();
            if (k == DEB + 2) check("run_not_yet", running, 0);
            if (k == DEB + 3) check("run_on", running, 1);
        end
        t0 = tick_seen;
        for (int n = 1; n <= 3 * CLK_FREQ; n++) begin
            tick_clk();
            if (n == 3) btn_run = 1'b0;
            check("t1_tick", tick, (n % CLK_FREQ) == 0);
            check("t1_leds", leds, n / CLK_FREQ);
        end
        check("t1_tick_count", tick_seen - t0, 3);
        $display("test1 leds %02h running %0d", leds, running);

        // Test 2: pause, down steps, step ignored in RUN.
        press(0);
        check("t2_paused", running, 0);
        check("t2_leds_held", leds, 3);
        load_valid = 1'b1; load_data = 8'h05;
        tick_clk();
        load_valid = 1'b0;
        check("t2_load5", leds, 8'h05);
        t0 = tick_seen;
        press(3);
        check("t2_down", down, 1);
        press(1);
        check("t2_step1", leds, 8'h04);
        press(1);
        check("t2_step2", leds, 8'h03);
        check("t2_no_tick", tick_seen - t0, 0);
        t0 = tick_seen;
        press(0);
        press(1);
        check("t2_run_ticks", tick_seen - t0, 1);
        check("t2_step_in_run", leds, 8'h02);
        check("t2_running", running, 1);

        // Test 3a and 5: wrap up, load colliding with tick, speed change.
        press(3);
        check("t3_up", down, 0);
        load_then_tick(8'hFF, 8'h00);
        repeat (CLK_FREQ - 1) tick_clk();
        load_then_tick(8'h10, 8'h11);
        repeat (5) tick_clk();
        speed = 2'd3;
        tick_clk();
        check("t5_restart0", tick, 0);
        tick_clk();
        check("t5_restart1", tick, 0);
        tick_clk();
        check("t5_fast_tick", tick, 1);
        check("t5_fast_leds", leds, 8'h12);
        speed = 2'd0;

        // Test 3b: wrap down.
        press(3);
        check("t3_down", down, 1);
        load_then_tick(8'h00, 8'hFF);

        // Test 4: load held off during the clear event cycle.
        btn_clear = 1'b1;
        repeat (DEB + 1) tick_clk();
        check("t4_ready_before", load_ready, 1);
        tick_clk();
        check("t4_ready_clear", load_ready, 0);
        load_valid = 1'b1; load_data = 8'hA5;
        tick_clk();
        check("t4_cleared", leds, 8'h00);
        check("t4_ready_again", load_ready, 1);
        tick_clk();
        check("t4_loaded", leds, 8'hA5);
        load_valid = 1'b0;
        btn_clear = 1'b0;
        repeat (DEB + 3) tick_clk();

        // Test 6: bouncing run button gives a single toggle.
        bounce = 25'h1FF_FFFB;
        toggles = 0;
        last_run = running;
        for (int i = 0; i < 25; i++) begin
            btn_run = (i == 2) ? 1'b0 : 1'b1;
            tick_clk();
            if (running !== last_run) toggles++;
            last_run = running;
        end
        check("t6_toggles", toggles, 1);
        check("t6_paused", running, 0);
        btn_run = 1'b0;
        repeat (DEB + 3) tick_clk();

        // Load vector table while paused.
        for (int i = 0; i < 8; i++) begin
            load_valid = vecs[i].lv;
            load_data  = vecs[i].ld;
            #1;
            check("tbl_ready", load_ready, 1);
            tick_clk();
            check("tbl_leds", leds, vecs[i].exp_leds);
            check("tbl_tick", tick, 0);
            $display("vec %0d valid %0d data %02h leds %02h", i, vecs[i].lv, vecs[i].ld, leds);
        end
        load_valid = 1'b0;

        // Randomized RUN-mode loads and speed changes, down = 1.
        press(0);
        check("rnd_running", running, 1);
        m_e = 0; m_leds = 8'h00; m_sprev = 2'd0; spd = 2'd0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            lv = (cyc == 0) || ($urandom_range(0, 7) == 0);
            ld = 8'($urandom_range(0, 255));
            if (cyc > 0 && $urandom_range(0, 19) == 0) begin
                nspd = 2'($urandom_range(0, 3));
                if (m_e != (CLK_FREQ >> nspd) - 1) spd = nspd;
            end
            per = CLK_FREQ >> spd;
            if (lv) begin
                m_leds = ld; m_tick = 1'b0; m_e = 0;
            end else if (m_e == per - 1) begin
                m_leds = m_leds - 8'd1; m_tick = 1'b1; m_e = 0;
            end else begin
                m_tick = 1'b0;
                m_e = (spd != m_sprev) ? 0 : m_e + 1;
            end
            m_sprev = spd;
            load_valid = lv; load_data = ld; speed = spd;
            #1;
            check("rnd_ready", load_ready, 1);
            tick_clk();
            check("rnd_leds", leds, m_leds);
            check("rnd_tick", tick, m_tick);
            if (lv) $display("rnd cyc %0d load %02h speed %0d", cyc, ld, spd);
        end
        load_valid = 1'b0;
        speed = 2'd0;

        // Reset in the middle of RUN.
        load_valid = 1'b1; load_data = 8'h5A;
        tick_clk();
        load_valid = 1'b0;
        check("pre_rst_leds", leds, 8'h5A);
        rst = 1'b1;
        tick_clk();
        check("mid_rst_leds", leds, 0);
        check("mid_rst_running", running, 0);
        check("mid_rst_down", down, 0);
        check("mid_rst_tick", tick, 0);
        check("mid_rst_ready", load_ready, 0);
        rst = 1'b0;
        repeat (3) tick_clk();
        check("post_rst_running", running, 0);
        check("post_rst_leds", leds, 0);
        check("post_rst_ready", load_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
